// File: rtl/board_ctl.sv
// Board controller for a grid game: clears the board, places ship segments and
// resolves shots against an external board memory with a 1-cycle registered read.
module board_ctl #(
  parameter int X_SIZE       = 12,
  parameter int Y_SIZE       = 12,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_req,
  input  logic                                 shot_req,
  input  logic [X_ADDR_WIDTH-1:0]              shot_x,
  input  logic [Y_ADDR_WIDTH-1:0]              shot_y,
  input  logic                                 place_req,
  input  logic [X_ADDR_WIDTH-1:0]              place_x,
  input  logic [Y_ADDR_WIDTH-1:0]              place_y,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic                                 mem_w_nr,
  output logic                                 busy,
  output logic                                 clear_done,
  output logic                                 shot_done,
  output logic                                 shot_hit,
  output logic                                 shot_repeat,
  output logic                                 place_done,
  output logic                                 place_ok,
  output logic                                 req_err,
  output logic [7:0]                           ship_cells,
  output logic                                 all_sunk
);

  localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH;
  localparam logic [X_ADDR_WIDTH:0]   X_LIM     = (X_ADDR_WIDTH + 1)'(X_SIZE);
  localparam logic [Y_ADDR_WIDTH:0]   Y_LIM     = (Y_ADDR_WIDTH + 1)'(Y_SIZE);
  localparam logic [X_ADDR_WIDTH-1:0] X_LAST    = X_ADDR_WIDTH'(X_SIZE - 1);
  localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST    = Y_ADDR_WIDTH'(Y_SIZE - 1);
  localparam logic [X_ADDR_WIDTH-1:0] X_ZERO    = X_ADDR_WIDTH'(0);
  localparam logic [Y_ADDR_WIDTH-1:0] Y_ZERO    = Y_ADDR_WIDTH'(0);
  localparam logic [X_ADDR_WIDTH-1:0] X_ONE     = X_ADDR_WIDTH'(1);
  localparam logic [Y_ADDR_WIDTH-1:0] Y_ONE     = Y_ADDR_WIDTH'(1);
  localparam logic [AW-1:0]           ADDR_ZERO = AW'(0);
  localparam logic [7:0]              MAX_CELLS = 8'(X_SIZE * Y_SIZE);

  localparam logic [DATA_WIDTH-1:0] CELL_EMPTY = DATA_WIDTH'(2'b00);
  localparam logic [DATA_WIDTH-1:0] CELL_SHIP  = DATA_WIDTH'(2'b01);
  localparam logic [DATA_WIDTH-1:0] CELL_MISS  = DATA_WIDTH'(2'b10);
  localparam logic [DATA_WIDTH-1:0] CELL_HIT   = DATA_WIDTH'(2'b11);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    SHOT_RD    = 3'd2,
    SHOT_EVAL  = 3'd3,
    PLACE_RD   = 3'd4,
    PLACE_EVAL = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t                  state_r;
  logic [X_ADDR_WIDTH-1:0] x_r;
  logic [Y_ADDR_WIDTH-1:0] y_r;
  logic [X_ADDR_WIDTH-1:0] x_nxt_s;
  logic [Y_ADDR_WIDTH-1:0] y_nxt_s;
  logic                    shot_bad_s;
  logic                    place_bad_s;
  logic [7:0]              cells_dec_s;
  logic [7:0]              cells_inc_s;

  // Range checks, clear-walk successors and saturating ship counter steps.
  always_comb begin
    shot_bad_s  = ({1'b0, shot_x} >= X_LIM) || ({1'b0, shot_y} >= Y_LIM);
    place_bad_s = ({1'b0, place_x} >= X_LIM) || ({1'b0, place_y} >= Y_LIM);
    x_nxt_s     = x_r + X_ONE;
    y_nxt_s     = y_r + Y_ONE;
    cells_dec_s = (ship_cells == 8'd0) ? 8'd0 : (ship_cells - 8'd1);
    cells_inc_s = (ship_cells >= MAX_CELLS) ? MAX_CELLS : (ship_cells + 8'd1);
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      x_r         <= X_ZERO;
      y_r         <= Y_ZERO;
      mem_addr    <= ADDR_ZERO;
      mem_wdata   <= CELL_EMPTY;
      mem_w_nr    <= 1'b0;
      busy        <= 1'b0;
      clear_done  <= 1'b0;
      shot_done   <= 1'b0;
      shot_hit    <= 1'b0;
      shot_repeat <= 1'b0;
      place_done  <= 1'b0;
      place_ok    <= 1'b0;
      req_err     <= 1'b0;
      ship_cells  <= 8'd0;
      all_sunk    <= 1'b0;
    end else begin
      clear_done  <= 1'b0;
      shot_done   <= 1'b0;
      shot_hit    <= 1'b0;
      shot_repeat <= 1'b0;
      place_done  <= 1'b0;
      place_ok    <= 1'b0;
      req_err     <= 1'b0;
      case (state_r)
        IDLE: begin
          mem_w_nr  <= 1'b0;
          mem_addr  <= ADDR_ZERO;
          mem_wdata <= CELL_EMPTY;
          busy      <= 1'b0;
          if (clear_req) begin
            state_r  <= CLEAR;
            busy     <= 1'b1;
            x_r      <= X_ZERO;
            y_r      <= Y_ZERO;
            mem_w_nr <= 1'b1;
          end else if (shot_req) begin
            if (shot_bad_s) begin
              req_err <= 1'b1;
            end else begin
              state_r  <= SHOT_RD;
              busy     <= 1'b1;
              x_r      <= shot_x;
              y_r      <= shot_y;
              mem_addr <= {shot_x, shot_y};
            end
          end else if (place_req) begin
            if (place_bad_s) begin
              req_err <= 1'b1;
            end else begin
              state_r  <= PLACE_RD;
              busy     <= 1'b1;
              x_r      <= place_x;
              y_r      <= place_y;
              mem_addr <= {place_x, place_y};
            end
          end else begin
            state_r <= IDLE;
          end
        end
        // x_r/y_r track the cell currently being written; x is the inner index.
        CLEAR: begin
          if ((x_r == X_LAST) && (y_r == Y_LAST)) begin
            state_r    <= DONE;
            mem_w_nr   <= 1'b0;
            mem_addr   <= ADDR_ZERO;
            clear_done <= 1'b1;
            ship_cells <= 8'd0;
            all_sunk   <= 1'b0;
          end else if (x_r == X_LAST) begin
            x_r      <= X_ZERO;
            y_r      <= y_nxt_s;
            mem_addr <= {X_ZERO, y_nxt_s};
          end else begin
            x_r      <= x_nxt_s;
            mem_addr <= {x_nxt_s, y_r};
          end
        end
        SHOT_RD: state_r <= SHOT_EVAL;
        SHOT_EVAL: begin
          state_r   <= DONE;
          shot_done <= 1'b1;
          case (mem_rdata)
            CELL_SHIP: begin
              mem_w_nr   <= 1'b1;
              mem_wdata  <= CELL_HIT;
              shot_hit   <= 1'b1;
              ship_cells <= cells_dec_s;
              all_sunk   <= (cells_dec_s == 8'd0);
            end
            CELL_EMPTY: begin
              mem_w_nr  <= 1'b1;
              mem_wdata <= CELL_MISS;
            end
            default: begin
              mem_w_nr    <= 1'b0;
              shot_repeat <= 1'b1;
            end
          endcase
        end
        PLACE_RD: state_r <= PLACE_EVAL;
        PLACE_EVAL: begin
          state_r    <= DONE;
          place_done <= 1'b1;
          if (mem_rdata == CELL_EMPTY) begin
            mem_w_nr   <= 1'b1;
            mem_wdata  <= CELL_SHIP;
            place_ok   <= 1'b1;
            ship_cells <= cells_inc_s;
            all_sunk   <= 1'b0;
          end else begin
            mem_w_nr <= 1'b0;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          mem_w_nr  <= 1'b0;
          mem_addr  <= ADDR_ZERO;
          mem_wdata <= CELL_EMPTY;
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          mem_w_nr  <= 1'b0;
          mem_addr  <= ADDR_ZERO;
          mem_wdata <= CELL_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_ctl.sv
// Directed self-checking bench for board_ctl with a behavioural board memory
// (registered read, write on mem_w_nr).
module tb_board_ctl;

  logic       clk = 1'b0;
  logic       rst, clear_req, shot_req, place_req;
  logic [3:0] shot_x, shot_y, place_x, place_y;
  logic [1:0] mem_rdata;
  logic [7:0] mem_addr;
  logic [1:0] mem_wdata;
  logic       mem_w_nr, busy, clear_done, shot_done, shot_hit, shot_repeat;
  logic       place_done, place_ok, req_err, all_sunk;
  logic [7:0] ship_cells;

  logic [1:0] mem [256];
  int n_total = 0;
  int n_bad   = 0;
  int n_wr = 0, n_cd = 0, n_sd = 0, n_pd = 0;

  always #5 clk = ~clk;

  board_ctl dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .shot_req(shot_req),
    .shot_x(shot_x), .shot_y(shot_y), .place_req(place_req),
    .place_x(place_x), .place_y(place_y), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_nr(mem_w_nr),
    .busy(busy), .clear_done(clear_done), .shot_done(shot_done),
    .shot_hit(shot_hit), .shot_repeat(shot_repeat), .place_done(place_done),
    .place_ok(place_ok), .req_err(req_err), .ship_cells(ship_cells),
    .all_sunk(all_sunk)
  );

  always @(posedge clk) begin
    if (mem_w_nr === 1'b1) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_w_nr === 1'b1)   n_wr <= n_wr + 1;
    if (clear_done === 1'b1) n_cd <= n_cd + 1;
    if (shot_done === 1'b1)  n_sd <= n_sd + 1;
    if (place_done === 1'b1) n_pd <= n_pd + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // exp_res = {shot_done, shot_hit, shot_repeat, place_done, place_ok} in the done cycle
  task automatic run_op(input string tag, input bit is_shot, input logic [3:0] x,
                        input logic [3:0] y, input bit exp_wr, input logic [1:0] exp_wd,
                        input logic [4:0] exp_res, input logic [7:0] exp_cells,
                        input bit exp_sunk);
    if (is_shot) begin
      shot_req = 1'b1; shot_x = x; shot_y = y;
    end else begin
      place_req = 1'b1; place_x = x; place_y = y;
    end
    @(negedge clk);
    shot_req = 1'b0; place_req = 1'b0;
    shot_x = ~x; shot_y = ~y; place_x = ~x; place_y = ~y;
    check_val({tag, "_rd"}, {busy, mem_w_nr, mem_addr}, {1'b1, 1'b0, x, y});
    @(negedge clk);
    check_val({tag, "_ev"}, {busy, mem_w_nr, shot_done, place_done}, 4'b1000);
    @(negedge clk);
    check_val({tag, "_res"}, {shot_done, shot_hit, shot_repeat, place_done, place_ok}, exp_res);
    check_val({tag, "_wen"}, mem_w_nr, exp_wr);
    if (exp_wr) check_val({tag, "_wr"}, {mem_addr, mem_wdata}, {x, y, exp_wd});
    check_val({tag, "_cells"}, ship_cells, exp_cells);
    check_val({tag, "_sunk"}, {busy, all_sunk}, {1'b1, exp_sunk});
    @(negedge clk);
    check_val({tag, "_end"}, {busy, shot_done, place_done, mem_w_nr, mem_addr}, 12'h000);
  endtask

  task automatic run_err(input string tag, input bit is_shot, input logic [3:0] x, input logic [3:0] y);
    int w0;
    w0 = n_wr;
    if (is_shot) begin
      shot_req = 1'b1; shot_x = x; shot_y = y;
    end else begin
      place_req = 1'b1; place_x = x; place_y = y;
    end
    @(negedge clk);
    shot_req = 1'b0; place_req = 1'b0;
    check_val({tag, "_pulse"}, {req_err, busy, mem_w_nr}, 3'b100);
    @(negedge clk);
    check_val({tag, "_after"}, {req_err, busy, mem_w_nr}, 3'b000);
    @(negedge clk);
    check_val({tag, "_nowr"}, n_wr - w0, 0);
  endtask

  task automatic run_clear(input string tag, input bit all_reqs);
    int sd0, pd0;
    sd0 = n_sd; pd0 = n_pd;
    clear_req = 1'b1;
    if (all_reqs) begin
      shot_req = 1'b1; shot_x = 4'd1; shot_y = 4'd1;
      place_req = 1'b1; place_x = 4'd2; place_y = 4'd2;
    end
    @(negedge clk);
    clear_req = 1'b0; shot_req = 1'b0; place_req = 1'b0;
    for (int i = 0; i < 144; i++) begin
      logic [3:0] ex, ey;
      ex = 4'(i % 12);
      ey = 4'(i / 12);
      check_val({tag, "_wr"}, {mem_w_nr, busy, mem_addr, mem_wdata, clear_done},
                {1'b1, 1'b1, ex, ey, 2'b00, 1'b0});
      if (i == 20) begin
        shot_req = 1'b1; place_req = 1'b1;
        shot_x = 4'd1; shot_y = 4'd1; place_x = 4'd2; place_y = 4'd2;
      end else begin
        shot_req = 1'b0; place_req = 1'b0;
      end
      @(negedge clk);
    end
    check_val({tag, "_done"}, {clear_done, busy, mem_w_nr, ship_cells, all_sunk},
              {1'b1, 1'b1, 1'b0, 8'd0, 1'b0});
    @(negedge clk);
    check_val({tag, "_idle"}, {clear_done, busy, mem_w_nr}, 3'b000);
    check_val({tag, "_drop"}, (n_sd - sd0) + (n_pd - pd0), 0);
  endtask

  initial begin
    int w0, c0, nz;
    for (int i = 0; i < 256; i++) mem[i] = 2'b10;
    mem_rdata = 2'b00;
    rst = 1'b1; clear_req = 1'b0; shot_req = 1'b0; place_req = 1'b0;
    shot_x = 4'd0; shot_y = 4'd0; place_x = 4'd0; place_y = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst_out", {busy, mem_w_nr, mem_addr, mem_wdata, clear_done, shot_done, shot_hit,
              shot_repeat, place_done, place_ok, req_err, ship_cells, all_sunk}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_out", {busy, mem_w_nr, mem_addr, mem_wdata}, 0);

    // clear with shot and place requested in the same cycle
    run_clear("clr1", 1'b1);
    nz = 0;
    for (int i = 0; i < 144; i++) if (mem[{4'(i % 12), 4'(i / 12)}] != 2'b00) nz++;
    check_val("clr1_mem", nz, 0);
    check_val("clr1_outside", mem[8'hC0], 2'b10);

    run_op("place35",  1'b0, 4'd3, 4'd5, 1'b1, 2'b01, 5'b00011, 8'd1, 1'b0);
    run_op("place35r", 1'b0, 4'd3, 4'd5, 1'b0, 2'b00, 5'b00010, 8'd1, 1'b0);
    run_op("shot35",   1'b1, 4'd3, 4'd5, 1'b1, 2'b11, 5'b11000, 8'd0, 1'b1);
    run_op("shot35r",  1'b1, 4'd3, 4'd5, 1'b0, 2'b00, 5'b10100, 8'd0, 1'b1);
    run_op("shot45",   1'b1, 4'd4, 4'd5, 1'b1, 2'b10, 5'b10000, 8'd0, 1'b1);
    run_err("err_shot12_0",  1'b1, 4'd12, 4'd0);
    run_err("err_place0_12", 1'b0, 4'd0,  4'd12);
    run_err("err_shot5_15",  1'b1, 4'd5,  4'd15);
    run_op("placeBB", 1'b0, 4'd11, 4'd11, 1'b1, 2'b01, 5'b00011, 8'd1, 1'b0);
    run_op("place24", 1'b0, 4'd2,  4'd4,  1'b1, 2'b01, 5'b00011, 8'd2, 1'b0);
    run_op("place00", 1'b0, 4'd0,  4'd0,  1'b1, 2'b01, 5'b00011, 8'd3, 1'b0);

    // reset during the 50th clear write cycle
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 49) rst = 1'b1;
      @(negedge clk);
    end
    check_val("rstc_out", {busy, mem_w_nr, mem_addr, clear_done, ship_cells, all_sunk}, 0);
    rst = 1'b0;
    w0 = n_wr; c0 = n_cd;
    repeat (10) @(negedge clk);
    check_val("rstc_nowr", n_wr - w0, 0);
    check_val("rstc_nodone", n_cd - c0, 0);
    check_val("rstc_mem_cleared", mem[8'h00], 2'b00);
    check_val("rstc_mem_kept24", mem[8'h24], 2'b01);
    check_val("rstc_mem_keptBB", mem[8'hBB], 2'b01);

    // ships left in memory while the counter is zero: decrement saturates
    run_op("shot24_sat", 1'b1, 4'd2,  4'd4,  1'b1, 2'b11, 5'b11000, 8'd0, 1'b1);
    run_op("shotBB_sat", 1'b1, 4'd11, 4'd11, 1'b1, 2'b11, 5'b11000, 8'd0, 1'b1);

    // fill the whole board up to the 144 ceiling
    run_clear("clr2", 1'b0);
    for (int i = 0; i < 144; i++)
      run_op("fill", 1'b0, 4'(i % 12), 4'(i / 12), 1'b1, 2'b01, 5'b00011, 8'(i + 1), 1'b0);
    check_val("fill_full", ship_cells, 8'd144);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
